alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Synthesizable response checker for the 4-bit ALU. It accepts one sample per handshake, where each sample holds the operands and opcode applied to the ALU plus the ALU's observed outputs. It recomputes the expected outputs with an internal golden model, compares them, and keeps pass/fail counts and the first failure. It pairs with the ALU stimulus source as the receiving end of the same operand/response stream, for on-chip self-test and bench scoreboarding.

## Interface

Parameters:
- `WIDTH`, 4: operand and result width.
- `CNT_W`, 16: width of the vector, pass and fail counters.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse. Clears all status and arms a run.
- `num_vectors`, input, `CNT_W`: number of samples expected. Latched on `start`.
- `s_valid`, input, 1: sample valid.
- `s_ready`, output, 1: checker can accept a sample.
- `s_a`, `s_b`, input, `WIDTH` each: operands applied to the ALU.
- `s_opcode`, input, 3: opcode applied to the ALU.
- `s_result`, input, `WIDTH`: observed ALU result.
- `s_carry`, `s_zero`, `s_overflow`, input, 1 each: observed ALU flags.
- `busy`, output, 1: run in progress.
- `done`, output, 1: run complete. Held until the next `start`.
- `pass`, output, 1: `done` and `fail_cnt` is 0.
- `pass_cnt`, `fail_cnt`, output, `CNT_W` each: compare outcomes.
- `first_fail_valid`, output, 1: at least one mismatch seen.
- `first_fail_idx`, output, `CNT_W`: zero-based index of the first mismatching sample.
- `first_fail_mask`, output, 4: mismatch bits {result, carry, zero, overflow} of the first failure.

## Operation

Golden model (`r` is the `WIDTH`-bit result; `zero` = (`r` == 0) for every opcode):
- 000 ADD: `r` = A+B. `carry` = bit `WIDTH` of the unsigned sum. `overflow` = the operands share a sign and `r`'s sign differs.
- 001 SUB: `r` = A−B. `carry` = borrow (A < B unsigned). `overflow` = the operands have different signs and `r`'s sign differs from A's.
- 010 AND, 011 OR, 100 XOR: bitwise. `carry` = 0, `overflow` = 0.
- 101 NOT: `r` = ~A, B ignored. `carry` = 0, `overflow` = 0.
- 110 SHL: `r` = A<<1. `carry` = A[`WIDTH`−1]. `overflow` = 0.
- 111 SHR (logical): `r` = A>>1. `carry` = A[0]. `overflow` = 0.

State machine (states IDLE, RUN, DONE):
- IDLE → RUN on `start` with `num_vectors` ≠ 0.
- IDLE → DONE on `start` with `num_vectors` = 0; `pass` = 1.
- RUN → DONE when the accepted count equals `num_vectors` and the compare stage is empty.
- DONE → RUN or DONE on `start`, by the same rule as IDLE.
- `start` in any state, including RUN, restarts the run: counters, first-fail record and in-flight sample are cleared, and `num_vectors` is relatched.

Acceptance and counting:
- `s_ready` = (state == RUN) and accepted count < `num_vectors`.
- A sample is accepted on a rising edge where `s_valid` and `s_ready` are both high.
- While `s_ready` is 0, `s_valid` is ignored and no sample is taken.
- The counters saturate at 2^`CNT_W`−1 and never wrap.
- The first-fail record is written only once per run.

## Timing

- Reset values: state IDLE; all outputs 0, including `s_ready`, `busy`, `done`, `pass`, counters and `first_fail_*`.
- Edge E (accept): the sample is registered into the compare stage.
- Edge E+1: the compare runs combinationally off the registered sample. `pass_cnt`/`fail_cnt` update and, on the first mismatch, `first_fail_*` are written.
- Full throughput: one sample per cycle.
- After the last sample is accepted at E, `done` rises at E+2 and `busy` falls at E+2.
- `start` takes priority over a simultaneous accept; that sample is discarded.
- `busy` = (state == RUN).
- Asserting `rst_n` low mid-run returns the block to reset values immediately.

## Structure

- Shared package `alu_pkg` holds:
  - the opcode constants `OP_ADD` … `OP_SHR`;
  - the state encoding (IDLE, RUN, DONE);
  - the mismatch-mask bit positions.
- The golden model is the sub-module `alu_ref_model`: combinational, parameterized by `WIDTH`, reusable by the stimulus side.
- The checker holds:
  - the FSM;
  - the one-stage sample register;
  - the counters;
  - the first-fail capture.

## Test plan

- Reset, then `start`, `num_vectors`=2, then the samples below → `done` at accept+2, `pass`=1, `pass_cnt`=2:
  - ADD 0101+0011 with result 1000, c0 z0 v1;
  - ADD 0111+0001 with result 1000, c0 z0 v1.
- SUB: 1000−0001 with result 0111, c0 v1; then 0011−0011 with result 0000, z1 c0 → both pass.
- AND 1100,1010 with result 1000; NOT 1100 with result 0011; SHL 0001 with result 0010, c0; SHR 1000 with result 0100, c0 → all pass.
- Corrupted sample: index 1 is XOR 1100,1010 reported as 0111 instead of 0110 → `fail_cnt`=1, `first_fail_idx`=1, `first_fail_mask`=1000, `pass`=0.
- Backpressure and edge cases:
  - `s_valid` held high past `num_vectors`=3 → exactly 3 accepted, `s_ready` low afterwards;
  - `start` with `num_vectors`=0 → `done`=1, `pass`=1 on the next cycle.
- Restart and reset:
  - `start` re-pulsed mid-run after 2 accepts → counters return to 0 and the new `num_vectors` governs;
  - `rst_n` low mid-run → all outputs 0 without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU stimulus/response pair: opcodes,
// checker state encoding and mismatch-mask bit positions.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions inside the 4-bit mismatch mask {result, carry, zero, overflow}.
    localparam int MASK_RES   = 3;
    localparam int MASK_CARRY = 2;
    localparam int MASK_ZERO  = 1;
    localparam int MASK_OVF   = 0;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU. Shared by the checker and usable by
// the stimulus side to predict responses.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_opcode,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_overflow
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // The extra top bit of the widened difference is the borrow (A < B unsigned).
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Opcode decode: result plus carry/overflow flags.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                o_result   = w_sum[WIDTH-1:0];
                o_carry    = w_sum[WIDTH];
                o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result   = w_diff[WIDTH-1:0];
                o_carry    = w_diff[WIDTH];
                o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOT: o_result = ~i_a;
            OP_SHL: begin
                o_result = {i_a[WIDTH-2:0], 1'b0};
                o_carry  = i_a[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[WIDTH-1:1]};
                o_carry  = i_a[0];
            end
            default: ;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_result_checker.sv
// Response checker for the 4-bit ALU: registers each accepted sample, compares
// it against the golden model one cycle later, and keeps pass/fail counts plus
// a record of the first mismatch in the run.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    input  logic [2:0]       s_opcode,
    input  logic [WIDTH-1:0] s_result,
    input  logic             s_carry,
    input  logic             s_zero,
    input  logic             s_overflow,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [3:0]       first_fail_mask
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;

    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] r_acc_cnt;

    // One-stage sample register feeding the compare.
    logic             r_stg_valid;
    logic [WIDTH-1:0] r_stg_a;
    logic [WIDTH-1:0] r_stg_b;
    logic [2:0]       r_stg_op;
    logic [WIDTH-1:0] r_stg_res;
    logic             r_stg_c;
    logic             r_stg_z;
    logic             r_stg_v;
    logic [CNT_W-1:0] r_stg_idx;

    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_ff_valid;
    logic [CNT_W-1:0] r_ff_idx;
    logic [3:0]       r_ff_mask;

    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_ref_res;
    logic             w_ref_c;
    logic             w_ref_z;
    logic             w_ref_v;
    logic [3:0]       w_mask;
    logic             w_mismatch;

    alu_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .i_a        (r_stg_a),
        .i_b        (r_stg_b),
        .i_opcode   (r_stg_op),
        .o_result   (w_ref_res),
        .o_carry    (w_ref_c),
        .o_zero     (w_ref_z),
        .o_overflow (w_ref_v)
    );

    assign w_ready  = (r_state == ST_RUN) && (r_acc_cnt < r_num_vec);
    // start wins over a coincident handshake; that sample is dropped.
    assign w_accept = s_valid && w_ready && !start;

    // Mismatch mask of the staged sample against the golden model.
    always_comb begin
        w_mask             = '0;
        w_mask[MASK_RES]   = (r_stg_res != w_ref_res);
        w_mask[MASK_CARRY] = (r_stg_c   != w_ref_c);
        w_mask[MASK_ZERO]  = (r_stg_z   != w_ref_z);
        w_mask[MASK_OVF]   = (r_stg_v   != w_ref_v);
    end

    assign w_mismatch = |w_mask;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: start restarts from any state; RUN ends once all samples are accepted and compared.
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = (num_vectors == '0) ? ST_DONE : ST_RUN;
        end else if (r_state == ST_RUN && r_acc_cnt == r_num_vec && !r_stg_valid) begin
            w_next_state = ST_DONE;
        end
    end

    // Run length latch, accept counter and sample stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_vec   <= '0;
            r_acc_cnt   <= '0;
            r_stg_valid <= 1'b0;
            r_stg_a     <= '0;
            r_stg_b     <= '0;
            r_stg_op    <= '0;
            r_stg_res   <= '0;
            r_stg_c     <= 1'b0;
            r_stg_z     <= 1'b0;
            r_stg_v     <= 1'b0;
            r_stg_idx   <= '0;
        end else if (start) begin
            r_num_vec   <= num_vectors;
            r_acc_cnt   <= '0;
            r_stg_valid <= 1'b0;
        end else begin
            r_stg_valid <= w_accept;
            if (w_accept) begin
                r_stg_a   <= s_a;
                r_stg_b   <= s_b;
                r_stg_op  <= s_opcode;
                r_stg_res <= s_result;
                r_stg_c   <= s_carry;
                r_stg_z   <= s_zero;
                r_stg_v   <= s_overflow;
                r_stg_idx <= r_acc_cnt;
                // Bounded by r_num_vec, so this cannot wrap.
                r_acc_cnt <= r_acc_cnt + CNT_ONE;
            end
        end
    end

    // Saturating pass/fail counters and once-per-run first-fail capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_ff_mask  <= '0;
        end else if (start) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
            r_ff_mask  <= '0;
        end else if (r_stg_valid) begin
            if (w_mismatch) begin
                if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_idx   <= r_stg_idx;
                    r_ff_mask  <= w_mask;
                end
            end else if (r_pass_cnt != CNT_MAX) begin
                r_pass_cnt <= r_pass_cnt + CNT_ONE;
            end
        end
    end

    assign s_ready          = w_ready;
    assign busy             = (r_state == ST_RUN);
    assign done             = (r_state == ST_DONE);
    assign pass             = (r_state == ST_DONE) && (r_fail_cnt == '0);
    assign pass_cnt         = r_pass_cnt;
    assign fail_cnt         = r_fail_cnt;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_idx   = r_ff_idx;
    assign first_fail_mask  = r_ff_mask;

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker. Expected mismatch masks come from
// an integer-arithmetic model and are queued per accepted sample; the queue is
// drained against the DUT's counters and first-fail record once done rises.
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vectors;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  s_a, s_b, s_result;
    logic [2:0]  s_opcode;
    logic        s_carry, s_zero, s_overflow;
    logic        busy, done, pass;
    logic [15:0] pass_cnt, fail_cnt, first_fail_idx;
    logic        first_fail_valid;
    logic [3:0]  first_fail_mask;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  sb_q[$];

    alu_result_checker #(.WIDTH(4), .CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .num_vectors      (num_vectors),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_a              (s_a),
        .s_b              (s_b),
        .s_opcode         (s_opcode),
        .s_result         (s_result),
        .s_carry          (s_carry),
        .s_zero           (s_zero),
        .s_overflow       (s_overflow),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .pass_cnt         (pass_cnt),
        .fail_cnt         (fail_cnt),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .first_fail_mask  (first_fail_mask)
    );

    always #5 clk = ~clk;

    // Independent model: signed/unsigned integer arithmetic, returns {res,c,z,v} mismatch bits.
    function automatic logic [3:0] model_mask(input logic [3:0] a, input logic [3:0] b,
                                              input logic [2:0] op, input logic [3:0] res,
                                              input logic c, input logic z, input logic v);
        int ua, ub, sa, sb, t, st;
        logic [3:0] r;
        logic ec, ev;
        ua = a; ub = b;
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        ec = 1'b0; ev = 1'b0; r = 4'h0; t = 0; st = 0;
        case (op)
            3'd0: begin t = ua + ub; r = t[3:0]; ec = (t > 15); st = sa + sb; ev = (st > 7) || (st < -8); end
            3'd1: begin t = ua - ub; r = t[3:0]; ec = (ua < ub); st = sa - sb; ev = (st > 7) || (st < -8); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[2:0], 1'b0}; ec = a[3]; end
            default: begin r = {1'b0, a[3:1]}; ec = a[0]; end
        endcase
        return {res != r, c != ec, z != (r == 4'h0), v != ev};
    endfunction

    task automatic pulse_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; num_vectors = n; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        sb_q.delete();
    endtask

    // Drives one sample, waits (bounded) for s_ready, and returns right after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] res, input logic c, input logic z, input logic v);
        int n;
        @(negedge clk);
        s_a = a; s_b = b; s_opcode = op; s_result = res;
        s_carry = c; s_zero = z; s_overflow = v; s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!s_ready) begin
            failures++;
            $display("FAIL send_ready_timeout s_ready=%b required=1", s_ready);
        end else begin
            sb_q.push_back(model_mask(a, b, op, res, c, z, v));
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Waits for done, then pops the scoreboard and compares the run's totals.
    task automatic drain(input string name);
        int n, idx, ep, ef;
        logic ffv;
        logic [15:0] ffi;
        logic [3:0] ffm, m;
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s done_timeout done=%b required=1", name, done);
        end
        ep = 0; ef = 0; ffv = 1'b0; ffi = '0; ffm = '0; idx = 0;
        while (sb_q.size() > 0) begin
            m = sb_q.pop_front();
            if (m != 4'h0) begin
                ef++;
                if (!ffv) begin ffv = 1'b1; ffi = 16'(idx); ffm = m; end
            end else begin
                ep++;
            end
            idx++;
        end
        checks++;
        if (pass_cnt !== 16'(ep)) begin failures++; $display("FAIL %s pass_cnt got=%0d exp=%0d", name, pass_cnt, ep); end
        checks++;
        if (fail_cnt !== 16'(ef)) begin failures++; $display("FAIL %s fail_cnt got=%0d exp=%0d", name, fail_cnt, ef); end
        checks++;
        if (first_fail_valid !== ffv) begin failures++; $display("FAIL %s ff_valid got=%b exp=%b", name, first_fail_valid, ffv); end
        checks++;
        if (first_fail_idx !== ffi || first_fail_mask !== ffm) begin
            failures++;
            $display("FAIL %s ff_idx/mask got=%0d/%b exp=%0d/%b", name, first_fail_idx, first_fail_mask, ffi, ffm);
        end
        checks++;
        if (pass !== (ef == 0)) begin failures++; $display("FAIL %s pass got=%b exp=%b", name, pass, (ef == 0)); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_vectors = '0; s_valid = 1'b0;
        s_a = '0; s_b = '0; s_opcode = '0; s_result = '0;
        s_carry = 1'b0; s_zero = 1'b0; s_overflow = 1'b0;
        #12;
        checks++;
        if ({s_ready, busy, done, pass, pass_cnt, fail_cnt, first_fail_valid, first_fail_idx, first_fail_mask} !== 57'd0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b busy=%b done=%b pass=%b pc=%0d fc=%0d ffv=%b required all 0",
                     s_ready, busy, done, pass, pass_cnt, fail_cnt, first_fail_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        pulse_start(16'd2);
        send(4'b0101, 4'b0011, 3'd0, 4'b1000, 1'b0, 1'b0, 1'b1);
        send(4'b0111, 4'b0001, 3'd0, 4'b1000, 1'b0, 1'b0, 1'b1);
        idle();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL add_e0 done/busy got=%b/%b exp=0/1", done, busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL add_e1 done/busy got=%b/%b exp=0/1", done, busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || pass_cnt !== 16'd2) begin
            failures++;
            $display("FAIL add_e2 done/busy/pass/pc got=%b/%b/%b/%0d exp=1/0/1/2", done, busy, pass, pass_cnt);
        end
        drain("add");
    endtask

    task automatic test_sub();
        pulse_start(16'd2);
        send(4'b1000, 4'b0001, 3'd1, 4'b0111, 1'b0, 1'b0, 1'b1);
        send(4'b0011, 4'b0011, 3'd1, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle();
        drain("sub");
    endtask

    task automatic test_logic();
        pulse_start(16'd4);
        send(4'b1100, 4'b1010, 3'd2, 4'b1000, 1'b0, 1'b0, 1'b0);
        send(4'b1100, 4'b0000, 3'd5, 4'b0011, 1'b0, 1'b0, 1'b0);
        send(4'b0001, 4'b0000, 3'd6, 4'b0010, 1'b0, 1'b0, 1'b0);
        send(4'b1000, 4'b0000, 3'd7, 4'b0100, 1'b0, 1'b0, 1'b0);
        idle();
        drain("logic");
        checks++;
        if (pass_cnt !== 16'd4) begin failures++; $display("FAIL logic_pass_cnt got=%0d exp=4", pass_cnt); end
    endtask

    task automatic test_corrupt();
        pulse_start(16'd3);
        send(4'b1100, 4'b1010, 3'd2, 4'b1000, 1'b0, 1'b0, 1'b0);
        send(4'b1100, 4'b1010, 3'd4, 4'b0111, 1'b0, 1'b0, 1'b0);
        send(4'b0010, 4'b0011, 3'd0, 4'b0101, 1'b0, 1'b0, 1'b0);
        idle();
        drain("corrupt");
        checks++;
        if (fail_cnt !== 16'd1 || first_fail_idx !== 16'd1 || first_fail_mask !== 4'b1000 || pass !== 1'b0) begin
            failures++;
            $display("FAIL corrupt_plan fc/idx/mask/pass got=%0d/%0d/%b/%b exp=1/1/1000/0",
                     fail_cnt, first_fail_idx, first_fail_mask, pass);
        end
    endtask

    // Two failures in a run: only the first is recorded.
    task automatic test_first_fail_once();
        pulse_start(16'd2);
        send(4'b1000, 4'b0000, 3'd6, 4'b0000, 1'b0, 1'b1, 1'b0);
        send(4'b0001, 4'b0010, 3'd3, 4'b0011, 1'b0, 1'b1, 1'b0);
        idle();
        drain("ff_once");
        checks++;
        if (fail_cnt !== 16'd2 || first_fail_idx !== 16'd0 || first_fail_mask !== 4'b0100) begin
            failures++;
            $display("FAIL ff_once fc/idx/mask got=%0d/%0d/%b exp=2/0/0100", fail_cnt, first_fail_idx, first_fail_mask);
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        pulse_start(16'd3);
        @(negedge clk);
        s_a = 4'b0110; s_b = 4'b0011; s_opcode = 3'd3; s_result = 4'b0111;
        s_carry = 1'b0; s_zero = 1'b0; s_overflow = 1'b0; s_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 7; i++) begin
            if (s_ready) begin
                accepted++;
                sb_q.push_back(model_mask(s_a, s_b, s_opcode, s_result, s_carry, s_zero, s_overflow));
            end
            @(negedge clk);
        end
        checks++;
        if (accepted != 3 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure accepted/ready got=%0d/%b exp=3/0", accepted, s_ready);
        end
        s_valid = 1'b0;
        drain("backpressure");
    endtask

    task automatic test_zero_vectors();
        @(negedge clk);
        start = 1'b1; num_vectors = 16'd0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_vectors done/pass/busy/ready got=%b/%b/%b/%b exp=1/1/0/0", done, pass, busy, s_ready);
        end
    endtask

    task automatic test_restart();
        pulse_start(16'd4);
        send(4'b0001, 4'b0001, 3'd0, 4'b0010, 1'b0, 1'b0, 1'b0);
        send(4'b0010, 4'b0001, 3'd1, 4'b0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; num_vectors = 16'd2; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        sb_q.delete();
        checks++;
        if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || busy !== 1'b1 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear pc/fc/busy/ready got=%0d/%0d/%b/%b exp=0/0/1/1", pass_cnt, fail_cnt, busy, s_ready);
        end
        send(4'b1111, 4'b0001, 3'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
        send(4'b0101, 4'b0000, 3'd7, 4'b0010, 1'b1, 1'b0, 1'b0);
        idle();
        drain("restart");
        checks++;
        if (pass_cnt !== 16'd2) begin failures++; $display("FAIL restart_pass_cnt got=%0d exp=2", pass_cnt); end
    endtask

    task automatic test_reset_midrun();
        pulse_start(16'd5);
        send(4'b0011, 4'b0101, 3'd2, 4'b0001, 1'b0, 1'b0, 1'b0);
        send(4'b0011, 4'b0101, 3'd2, 4'b0001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, busy, done, pass, pass_cnt, fail_cnt, first_fail_valid, first_fail_idx, first_fail_mask} !== 57'd0) begin
            failures++;
            $display("FAIL reset_midrun got ready=%b busy=%b done=%b pc=%0d fc=%0d required all 0",
                     s_ready, busy, done, pass_cnt, fail_cnt);
        end
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_corrupt();
        test_first_fail_once();
        test_backpressure();
        test_zero_vectors();
        test_restart();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
